// File: rtl/nios_pio_pkg.sv
// Shared register-map and mode constants for the Nios II input PIO.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_MODE    = 2'd3;

    localparam logic [1:0] MODE_RISE  = 2'd0;
    localparam logic [1:0] MODE_FALL  = 2'd1;
    localparam logic [1:0] MODE_ANY   = 2'd2;
    localparam logic [1:0] MODE_LEVEL = 2'd3;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } pio_req_t;

endpackage

// File: rtl/nios_pio_debounce.sv
// One input bit: two-flop synchroniser followed by an optional stability filter.
module nios_pio_debounce #(
    parameter int DEBOUNCE = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic filt_o
);

    localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign filt_o = sync2_q;
        end else begin : g_filter
            logic             filt_q, filt_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // filt only follows sync2 after DEBOUNCE consecutive disagreeing clocks
            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync2_q != filt_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                        filt_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filt_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/nios_pio_in_irq.sv
// Avalon-MM input PIO: synchronised/debounced level, per-bit edge capture with
// write-1-to-clear, maskable irq and a one-cycle registered read port.
module nios_pio_in_irq
    import nios_pio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    pio_req_t         req;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise, fall, edge_det, w1c;

    assign req = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_pio_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .pin_i  (in_port[i]),
            .filt_o (filt[i])
        );
    end

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

    always_comb begin
        edge_det = '0;
        case (mode_q)
            MODE_RISE: edge_det = rise;
            MODE_FALL: edge_det = fall;
            MODE_ANY:  edge_det = rise | fall;
            default:   edge_det = '0;
        endcase
    end

    assign w1c = (req.wr && req.addr == ADDR_EDGECAP) ? req.wdata[WIDTH-1:0] : '0;

    // a new edge overrides a clear of the same bit in the same cycle
    always_comb begin
        edgecap_d = (edgecap_q & ~w1c) | edge_det;
        irqmask_d = (req.wr && req.addr == ADDR_IRQMASK) ? req.wdata[WIDTH-1:0] : irqmask_q;
        mode_d    = (req.wr && req.addr == ADDR_MODE) ? req.wdata[1:0] : mode_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = filt;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d[1:0]       = mode_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            mode_q     <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= filt;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // level mode interrupts on the live filtered value, otherwise on captured edges
    assign irq = (mode_q == MODE_LEVEL) ? |(filt & irqmask_q) : |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_pio_in_irq.sv
// Directed bench: a bypass-debounce instance and a DEBOUNCE=4 instance on a shared bus.
module tb_nios_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd4;
    logic        irq0, irq4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    nios_pio_in_irq #(.WIDTH(8), .DEBOUNCE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    nios_pio_in_irq #(.WIDTH(8), .DEBOUNCE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd4), .irq(irq4)
    );

    typedef struct {
        logic [7:0]  in;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        in_port    = '0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [1:0] a);
        address = a;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // in, wr, addr, wdata, expected readdata / irq after the edge (bypass instance)
        tbl[0]  = '{8'h05, 1'b0, 2'd0, 32'h0,        32'h00, 1'b0};
        tbl[1]  = '{8'h05, 1'b0, 2'd0, 32'h0,        32'h00, 1'b0};
        tbl[2]  = '{8'h05, 1'b1, 2'd1, 32'h05,       32'h00, 1'b1};
        tbl[3]  = '{8'h05, 1'b0, 2'd0, 32'h0,        32'h05, 1'b1};
        tbl[4]  = '{8'h05, 1'b0, 2'd2, 32'h0,        32'h05, 1'b1};
        tbl[5]  = '{8'h05, 1'b0, 2'd1, 32'h0,        32'h05, 1'b1};
        tbl[6]  = '{8'h05, 1'b1, 2'd2, 32'h01,       32'h05, 1'b1};
        tbl[7]  = '{8'h05, 1'b0, 2'd2, 32'h0,        32'h04, 1'b1};
        tbl[8]  = '{8'h05, 1'b1, 2'd0, 32'hFF,       32'h05, 1'b1};
        tbl[9]  = '{8'h05, 1'b0, 2'd0, 32'h0,        32'h05, 1'b1};
        tbl[10] = '{8'h05, 1'b1, 2'd2, 32'hFF,       32'h04, 1'b0};
        tbl[11] = '{8'h05, 1'b1, 2'd3, 32'h1,        32'h00, 1'b0};
        tbl[12] = '{8'h04, 1'b0, 2'd3, 32'h0,        32'h01, 1'b0};
        tbl[13] = '{8'h04, 1'b0, 2'd3, 32'h0,        32'h01, 1'b0};
        tbl[14] = '{8'h04, 1'b1, 2'd1, 32'hFFFFFF01, 32'h05, 1'b1};
        tbl[15] = '{8'h04, 1'b0, 2'd2, 32'h0,        32'h01, 1'b1};
        tbl[16] = '{8'h04, 1'b1, 2'd2, 32'h01,       32'h01, 1'b0};
        tbl[17] = '{8'h04, 1'b0, 2'd2, 32'h0,        32'h00, 1'b0};
        tbl[18] = '{8'h04, 1'b0, 2'd1, 32'h0,        32'h01, 1'b0};

        reset_dut();
        chk("reset rd0", rd0, 32'h0);
        chk("reset irq0", {31'b0, irq0}, 32'h0);
        chk("reset rd4", rd4, 32'h0);
        chk("reset irq4", {31'b0, irq4}, 32'h0);

        // rise capture, mask, W1C, ignored DATA write, fall mode
        for (int i = 0; i < 19; i++) begin
            in_port    = tbl[i].in;
            address    = tbl[i].addr;
            writedata  = tbl[i].wd;
            chipselect = tbl[i].wr;
            write_n    = ~tbl[i].wr;
            tick();
            chk($sformatf("tbl[%0d] rd", i), rd0, tbl[i].exp_rd);
            chk($sformatf("tbl[%0d] irq", i), {31'b0, irq0}, {31'b0, tbl[i].exp_irq});
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // W1C landing in the same cycle as a fresh edge on that bit
        reset_dut();
        repeat (2) tick();
        in_port = 8'h04;
        repeat (3) tick();
        do_read(2'd2);
        chk("t4 pre", rd0, 32'h04);
        in_port = 8'h00;
        repeat (3) tick();
        in_port = 8'h04;
        repeat (2) tick();
        bus_wr(2'd2, 32'h04);
        do_read(2'd2);
        chk("t4 setwins", rd0, 32'h04);
        bus_wr(2'd2, 32'h04);
        do_read(2'd2);
        chk("t4 clear", rd0, 32'h00);

        // level mode: irq tracks bit7, EDGECAP held
        in_port = 8'h06;
        repeat (3) tick();
        bus_wr(2'd3, 32'h3);
        bus_wr(2'd1, 32'h80);
        in_port = 8'h86;
        tick();
        chk("t5 irq early", {31'b0, irq0}, 32'h0);
        tick();
        chk("t5 irq level", {31'b0, irq0}, 32'h1);
        do_read(2'd2);
        chk("t5 ecap held", rd0, 32'h02);
        in_port = 8'h06;
        repeat (2) tick();
        chk("t5 irq low", {31'b0, irq0}, 32'h0);
        do_read(2'd3);
        chk("t5 mode", rd0, 32'h3);

        // debounce: short pulse rejected, exact latency for a held level
        reset_dut();
        repeat (2) tick();
        in_port = 8'h01;
        repeat (3) tick();
        in_port = 8'h00;
        repeat (10) tick();
        chk("t2 pulse data", rd4, 32'h0);
        do_read(2'd2);
        chk("t2 pulse ecap", rd4, 32'h0);
        address = 2'd0;
        tick();
        in_port = 8'h01;
        repeat (6) tick();
        chk("t2 lat6", rd4, 32'h0);
        tick();
        chk("t2 lat7", rd4, 32'h1);

        // reset mid-debounce, then input high at release
        bus_wr(2'd1, 32'hFF);
        address = 2'd2;
        in_port = 8'hFF;
        repeat (4) tick();
        chk("t6 pre rd0", rd0, 32'hFF);
        chk("t6 pre irq0", {31'b0, irq0}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6 rst rd0", rd0, 32'h0);
        chk("t6 rst irq0", {31'b0, irq0}, 32'h0);
        chk("t6 rst rd4", rd4, 32'h0);
        chk("t6 rst irq4", {31'b0, irq4}, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (7) tick();
        chk("t6 rel7 rd4", rd4, 32'h0);
        tick();
        chk("t6 rel8 rd4", rd4, 32'hFF);
        chk("t6 rel8 rd0", rd0, 32'hFF);
        chk("t6 rel8 irq4", {31'b0, irq4}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
